// File: rtl/bdu_serializer.sv
// Bit-serial feeder for the BDU: streams a query/reference pair MSB-first (x,y,z interleaved)
// and returns the captured distance. Define EARLY_TERM_EN to honour bdu_terminate.
module bdu_serializer #(
    parameter int B    = 32,
    parameter int ID_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pt_valid,
    output logic            pt_ready,
    input  logic [B-1:0]    q_x,
    input  logic [B-1:0]    q_y,
    input  logic [B-1:0]    q_z,
    input  logic [B-1:0]    r_x,
    input  logic [B-1:0]    r_y,
    input  logic [B-1:0]    r_z,
    input  logic [2*B-1:0]  thr_in,
    input  logic [ID_W-1:0] pt_id,
    output logic            bdu_rst,
    output logic            bdu_q_bit,
    output logic            bdu_r_bit,
    output logic [1:0]      bdu_code,
    output logic [6:0]      bdu_which_bit,
    output logic [2*B-1:0]  bdu_threshold,
    input  logic            bdu_terminate,
    input  logic [B-1:0]    bdu_partial,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [B-1:0]    res_dist,
    output logic            res_pruned,
    output logic [ID_W-1:0] res_id
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    localparam logic [1:0] DIM_NONE = 2'b00;
    localparam logic [1:0] DIM_X    = 2'b01;
    localparam logic [1:0] DIM_Y    = 2'b10;
    localparam logic [1:0] DIM_Z    = 2'b11;
    localparam logic [6:0] B_LAST   = 7'(B);

    state_t          state_r, state_s;
    logic [6:0]      b_r, b_s;
    logic [1:0]      dim_r, dim_s;
    logic            accept_s, first_bit_s, last_bit_s, term_s, capture_s, res_hs_s;

    logic [B-1:0]    q_x_r, q_y_r, q_z_r, r_x_r, r_y_r, r_z_r;
    logic [ID_W-1:0] id_r;
    logic [2*B-1:0]  thr_r;

    logic [1:0]      code_s, code_r;
    logic            q_bit_s, q_bit_r, r_bit_s, r_bit_r;
    logic [6:0]      which_s, which_r, bit_idx_s;
    logic [B-1:0]    q_word_s, r_word_s, mask_s;

    logic            res_valid_r, res_pruned_r;
    logic [B-1:0]    res_dist_r;
    logic [ID_W-1:0] res_id_r;

    assign pt_ready      = (state_r == ST_IDLE);
    assign bdu_rst       = rst | (state_r == ST_CLEAR);
    assign bdu_code      = code_r;
    assign bdu_q_bit     = q_bit_r;
    assign bdu_r_bit     = r_bit_r;
    assign bdu_which_bit = which_r;
    assign bdu_threshold = thr_r;
    assign res_valid     = res_valid_r;
    assign res_dist      = res_dist_r;
    assign res_pruned    = res_pruned_r;
    assign res_id        = res_id_r;

    // Handshake and stream-position qualifiers
    always_comb begin
        accept_s    = pt_valid && (state_r == ST_IDLE);
        res_hs_s    = (state_r == ST_RESULT) && res_valid_r && res_ready;
        first_bit_s = (b_r == 7'd1) && (dim_r == DIM_X);
        last_bit_s  = (b_r == B_LAST) && (dim_r == DIM_Z);
`ifdef EARLY_TERM_EN
        // BDU state is still zero during the first bit, so its terminate is meaningless there
        term_s      = (state_r == ST_STREAM) && !first_bit_s && bdu_terminate;
`else
        term_s      = 1'b0;
`endif
        capture_s   = (state_r == ST_DRAIN) || term_s;
    end

`ifndef EARLY_TERM_EN
    logic unused_term_s;
    assign unused_term_s = bdu_terminate;
`endif

    // State and bit-position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            b_r     <= 7'd1;
            dim_r   <= DIM_X;
        end else begin
            state_r <= state_s;
            b_r     <= b_s;
            dim_r   <= dim_s;
        end
    end

    // Next-state and counter advance
    always_comb begin
        state_s = state_r;
        b_s     = b_r;
        dim_s   = dim_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_CLEAR;
                else          state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                state_s = ST_STREAM;
                b_s     = 7'd1;
                dim_s   = DIM_X;
            end
            ST_STREAM: begin
                if (term_s)          state_s = ST_RESULT;
                else if (last_bit_s) state_s = ST_DRAIN;
                else                 state_s = ST_STREAM;
                if (dim_r == DIM_Z) begin
                    dim_s = DIM_X;
                    if (b_r != B_LAST) b_s = b_r + 7'd1;
                    else               b_s = b_r;
                end else begin
                    dim_s = dim_r + 2'd1;
                end
            end
            ST_DRAIN:  state_s = ST_RESULT;
            ST_RESULT: begin
                if (res_hs_s) state_s = ST_IDLE;
                else          state_s = ST_RESULT;
            end
            default:   state_s = ST_IDLE;
        endcase
    end

    // Next BDU bit-lane values, aligned with the state being entered
    always_comb begin
        bit_idx_s = B_LAST - b_s;
        mask_s    = {{(B-1){1'b0}}, 1'b1} << bit_idx_s;
        case (dim_s)
            DIM_X:   begin q_word_s = q_x_r; r_word_s = r_x_r; end
            DIM_Y:   begin q_word_s = q_y_r; r_word_s = r_y_r; end
            DIM_Z:   begin q_word_s = q_z_r; r_word_s = r_z_r; end
            default: begin q_word_s = {B{1'b0}}; r_word_s = {B{1'b0}}; end
        endcase
        if (state_s == ST_STREAM) begin
            code_s  = dim_s;
            q_bit_s = |(q_word_s & mask_s);
            r_bit_s = |(r_word_s & mask_s);
            which_s = bit_idx_s << 1'b1;
        end else begin
            code_s  = DIM_NONE;
            q_bit_s = 1'b0;
            r_bit_s = 1'b0;
            which_s = 7'd0;
        end
    end

    // Pair latch, taken on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            q_x_r <= {B{1'b0}};
            q_y_r <= {B{1'b0}};
            q_z_r <= {B{1'b0}};
            r_x_r <= {B{1'b0}};
            r_y_r <= {B{1'b0}};
            r_z_r <= {B{1'b0}};
            id_r  <= {ID_W{1'b0}};
            thr_r <= {(2*B){1'b0}};
        end else if (accept_s) begin
            q_x_r <= q_x;
            q_y_r <= q_y;
            q_z_r <= q_z;
            r_x_r <= r_x;
            r_y_r <= r_y;
            r_z_r <= r_z;
            id_r  <= pt_id;
            thr_r <= thr_in;
        end
    end

    // Registered BDU lanes and result interface
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r       <= DIM_NONE;
            q_bit_r      <= 1'b0;
            r_bit_r      <= 1'b0;
            which_r      <= 7'd0;
            res_valid_r  <= 1'b0;
            res_dist_r   <= {B{1'b0}};
            res_pruned_r <= 1'b0;
            res_id_r     <= {ID_W{1'b0}};
        end else begin
            code_r      <= code_s;
            q_bit_r     <= q_bit_s;
            r_bit_r     <= r_bit_s;
            which_r     <= which_s;
            res_valid_r <= (state_r == ST_RESULT) && !res_hs_s;
            if (capture_s) begin
                res_dist_r   <= bdu_partial;
                res_pruned_r <= term_s;
                res_id_r     <= id_r;
            end
        end
    end

endmodule

// File: tb/tb_bdu_serializer.sv
// Directed bench for bdu_serializer (B=8) with a small behavioural BDU model.
module tb_bdu_serializer;
    localparam int B    = 8;
    localparam int ID_W = 8;

    logic            clk = 1'b0;
    logic            rst, pt_valid, pt_ready;
    logic [B-1:0]    q_x, q_y, q_z, r_x, r_y, r_z;
    logic [2*B-1:0]  thr_in;
    logic [ID_W-1:0] pt_id;
    logic            bdu_rst, bdu_q_bit, bdu_r_bit, bdu_terminate;
    logic [1:0]      bdu_code;
    logic [6:0]      bdu_which_bit;
    logic [2*B-1:0]  bdu_threshold;
    logic [B-1:0]    bdu_partial;
    logic            res_valid, res_ready, res_pruned;
    logic [B-1:0]    res_dist;
    logic [ID_W-1:0] res_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bdu_serializer #(.B(B), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .q_x(q_x), .q_y(q_y), .q_z(q_z), .r_x(r_x), .r_y(r_y), .r_z(r_z),
        .thr_in(thr_in), .pt_id(pt_id),
        .bdu_rst(bdu_rst), .bdu_q_bit(bdu_q_bit), .bdu_r_bit(bdu_r_bit),
        .bdu_code(bdu_code), .bdu_which_bit(bdu_which_bit), .bdu_threshold(bdu_threshold),
        .bdu_terminate(bdu_terminate), .bdu_partial(bdu_partial),
        .res_valid(res_valid), .res_ready(res_ready), .res_dist(res_dist),
        .res_pruned(res_pruned), .res_id(res_id)
    );

    // BDU model: rebuilds coordinates from the bit stream, distance from the known prefix
    logic [B-1:0] mqx, mqy, mqz, mrx, mry, mrz;
    int           dx, dy, dz;
    logic [31:0]  full;

    always_ff @(posedge clk) begin
        if (bdu_rst) begin
            mqx <= '0; mqy <= '0; mqz <= '0; mrx <= '0; mry <= '0; mrz <= '0;
        end else begin
            case (bdu_code)
                2'b01: begin mqx[bdu_which_bit >> 1] <= bdu_q_bit; mrx[bdu_which_bit >> 1] <= bdu_r_bit; end
                2'b10: begin mqy[bdu_which_bit >> 1] <= bdu_q_bit; mry[bdu_which_bit >> 1] <= bdu_r_bit; end
                2'b11: begin mqz[bdu_which_bit >> 1] <= bdu_q_bit; mrz[bdu_which_bit >> 1] <= bdu_r_bit; end
                default: begin end
            endcase
        end
    end

    assign dx            = int'(mqx) - int'(mrx);
    assign dy            = int'(mqy) - int'(mry);
    assign dz            = int'(mqz) - int'(mrz);
    assign full          = 32'(dx * dx + dy * dy + dz * dz);
    assign bdu_partial   = full[B-1:0];
    assign bdu_terminate = (full >= {16'd0, bdu_threshold});

    int         lat, n_stream, n_qones, n_rst;
    logic [1:0] first_code, last_code;
    logic [6:0] first_which, last_which;
    logic       first_qbit, seen_first;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        n_stream = 0; n_qones = 0; n_rst = 0; seen_first = 1'b0;
        first_code = 2'd0; last_code = 2'd0; first_which = 7'd0; last_which = 7'd0; first_qbit = 1'b0;
    endtask

    task automatic observe();
        if (bdu_rst) n_rst++;
        if (bdu_code != 2'd0) begin
            if (!seen_first) begin
                first_code = bdu_code; first_which = bdu_which_bit; first_qbit = bdu_q_bit;
                seen_first = 1'b1;
            end
            last_code = bdu_code; last_which = bdu_which_bit;
            n_stream++;
            if (bdu_q_bit) n_qones++;
        end
    endtask

    task automatic wait_result(input string tag);
        lat = 0;
        observe();
        while (!res_valid && lat < 60) begin
            step();
            lat++;
            observe();
        end
        check_val({tag, "_res_valid_seen"}, res_valid, 1);
    endtask

    task automatic offer_and_wait(input logic [B-1:0] qx, qy, qz, rx, ry, rz,
                                  input logic [2*B-1:0] thr, input logic [ID_W-1:0] id, input string tag);
        q_x = qx; q_y = qy; q_z = qz; r_x = rx; r_y = ry; r_z = rz; thr_in = thr; pt_id = id;
        pt_valid = 1'b1;
        step();
        pt_valid = 1'b0;
        clear_obs();
        wait_result(tag);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_pt_ready"}, pt_ready, 1);
        check_val({tag, "_bdu_rst"}, bdu_rst, 0);
        check_val({tag, "_code"}, bdu_code, 0);
        check_val({tag, "_q_bit"}, bdu_q_bit, 0);
        check_val({tag, "_r_bit"}, bdu_r_bit, 0);
        check_val({tag, "_which"}, bdu_which_bit, 0);
        check_val({tag, "_threshold"}, bdu_threshold, 0);
        check_val({tag, "_res_valid"}, res_valid, 0);
        check_val({tag, "_res_dist"}, res_dist, 0);
        check_val({tag, "_res_pruned"}, res_pruned, 0);
        check_val({tag, "_res_id"}, res_id, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int guard;
        rst = 1'b1; pt_valid = 1'b0; res_ready = 1'b0;
        q_x = '0; q_y = '0; q_z = '0; r_x = '0; r_y = '0; r_z = '0; thr_in = '0; pt_id = '0;
        step(); step();
        check_val("rst_bdu_rst_high", bdu_rst, 1);
        rst = 1'b0;
        step();
        check_idle("reset");

        // Full stream with back-pressure
        offer_and_wait(8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'hFFFF, 8'h11, "full");
        check_val("full_latency", lat, 27);
        check_val("full_dist", res_dist, 9);
        check_val("full_pruned", res_pruned, 0);
        check_val("full_id", res_id, 32'h11);
        check_val("full_stream_cycles", n_stream, 24);
        check_val("full_q_ones", n_qones, 2);
        check_val("full_clear_cycles", n_rst, 1);
        check_val("full_threshold", bdu_threshold, 32'hFFFF);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (res_valid !== 1'b1 || res_dist !== 8'd9 || res_pruned !== 1'b0 || res_id !== 8'h11 ||
                pt_ready !== 1'b0 || bdu_code !== 2'd0) bad++;
        end
        check_val("bp_stable", bad, 0);
        release_result();
        check_val("bp_pt_ready_after", pt_ready, 1);
        check_val("bp_res_valid_after", res_valid, 0);

        // Bit ordering: single MSB of q_x
        offer_and_wait(8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'hFFFF, 8'h22, "seq");
        check_val("seq_first_code", first_code, 1);
        check_val("seq_first_which", first_which, 14);
        check_val("seq_first_qbit", first_qbit, 1);
        check_val("seq_q_ones", n_qones, 1);
        check_val("seq_last_code", last_code, 3);
        check_val("seq_last_which", last_which, 0);
        check_val("seq_latency", lat, 27);
        check_val("seq_dist", res_dist, 0);
        release_result();

        // Early termination stimulus
        offer_and_wait(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 16'h0001, 8'h33, "term");
`ifdef EARLY_TERM_EN
        check_val("term_pruned", res_pruned, 1);
        check_val("term_latency", lat, 4);
        check_val("term_dist", res_dist, 0);
`else
        check_val("term_pruned", res_pruned, 0);
        check_val("term_latency", lat, 27);
        check_val("term_dist", res_dist, 3);
`endif
        check_val("term_id", res_id, 32'h33);
        check_val("term_threshold", bdu_threshold, 1);
        release_result();

        // Back-to-back with pt_valid and res_ready held high
        res_ready = 1'b1;
        q_x = 8'd2; q_y = 8'd0; q_z = 8'd0; r_x = 8'd0; r_y = 8'd0; r_z = 8'd0;
        thr_in = 16'hFFFF; pt_id = 8'hA1; pt_valid = 1'b1;
        step();
        q_x = 8'd0; q_y = 8'd5; r_y = 8'd1; pt_id = 8'hB2;
        clear_obs();
        wait_result("b2b_a");
        check_val("b2b_a_latency", lat, 27);
        check_val("b2b_a_id", res_id, 32'hA1);
        check_val("b2b_a_dist", res_dist, 4);
        step();
        check_val("b2b_pt_ready_after_hs", pt_ready, 1);
        check_val("b2b_res_valid_after_hs", res_valid, 0);
        step();
        pt_valid = 1'b0;
        check_val("b2b_second_accepted", pt_ready, 0);
        clear_obs();
        wait_result("b2b_b");
        check_val("b2b_b_latency", lat, 27);
        check_val("b2b_b_id", res_id, 32'hB2);
        check_val("b2b_b_dist", res_dist, 16);
        step();
        res_ready = 1'b0;

        // Reset in the fifth stream cycle
        q_x = 8'd9; q_y = 8'd9; q_z = 8'd9; r_x = 8'd1; r_y = 8'd1; r_z = 8'd1;
        thr_in = 16'hFFFF; pt_id = 8'h55; pt_valid = 1'b1;
        step();
        pt_valid = 1'b0;
        clear_obs();
        observe();
        guard = 0;
        while (n_stream < 5 && guard < 20) begin
            step();
            guard++;
            observe();
        end
        check_val("midrst_stream_cycle", n_stream, 5);
        rst = 1'b1;
        #1;
        check_val("midrst_bdu_rst", bdu_rst, 1);
        step();
        rst = 1'b0;
        #1;
        check_idle("midrst");
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (res_valid !== 1'b0 || pt_ready !== 1'b1) bad++;
        end
        check_val("midrst_no_result", bad, 0);

        // Recovery pair after reset
        offer_and_wait(8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd9, 16'hFFFF, 8'h44, "recover");
        check_val("recover_latency", lat, 27);
        check_val("recover_dist", res_dist, 61);
        check_val("recover_pruned", res_pruned, 0);
        check_val("recover_id", res_id, 32'h44);
        release_result();
        check_val("recover_pt_ready", pt_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
